// File: rtl/seq_mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_pkg
//  Description : Shared types and width helpers for the sequential
//                shift-add multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_mult_pkg;

    // Two-state controller: waiting for start, or iterating.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // Iteration counter width; never below one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    // Full product width for a given operand width.
    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

endpackage : seq_mult_pkg
`default_nettype wire

// File: rtl/seq_mult_sign_unit.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_sign_unit
//  Description : Combinational conditional two's-complement negation.
//                With neg tied to (signed & msb) it produces an absolute
//                value; with neg tied to the result sign it restores sign.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_sign_unit #(
    parameter int W = 6
) (
    input  logic [W-1:0] din,
    input  logic         neg,
    output logic [W-1:0] dout
);

    // Negating the most negative value yields 2^(W-1), which is still
    // the correct magnitude when read as unsigned.
    assign dout = neg ? (~din + W'(1)) : din;

endmodule : seq_mult_sign_unit
`default_nettype wire

// File: rtl/seq_mult_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_param
//  Description : Parametrised sequential shift-add multiplier with
//                signed/unsigned mode, start/busy/done handshake and
//                optional early termination.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_param
    import seq_mult_pkg::*;
#(
    parameter int WIDTH      = 6,
    parameter int EARLY_TERM = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int              c_PW   = prod_width(WIDTH);
    localparam int              c_CW   = cnt_width(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    state_t              r_state;
    logic [WIDTH-1:0]    r_x;
    logic [WIDTH-1:0]    r_y;
    logic [c_PW-1:0]     r_acc;
    logic [c_CW-1:0]     r_cnt;
    logic                r_neg;

    logic [WIDTH-1:0]    w_abs_a;
    logic [WIDTH-1:0]    w_abs_b;
    logic [c_PW-1:0]     w_addend;
    logic [c_PW-1:0]     w_nxt;
    logic [c_PW-1:0]     w_res;
    logic                w_fin;

    // Operand magnitudes; in unsigned mode the operands pass through raw.
    seq_mult_sign_unit #(.W(WIDTH)) u_abs_a (
        .din  (a),
        .neg  (signed_mode & a[WIDTH-1]),
        .dout (w_abs_a)
    );

    seq_mult_sign_unit #(.W(WIDTH)) u_abs_b (
        .din  (b),
        .neg  (signed_mode & b[WIDTH-1]),
        .dout (w_abs_b)
    );

    // Partial product for this iteration and the running sum it produces.
    assign w_addend = r_x[0] ? ({{WIDTH{1'b0}}, r_y} << r_cnt) : '0;
    assign w_nxt    = r_acc + w_addend;

    // Result sign restored from the sign latched at start.
    seq_mult_sign_unit #(.W(c_PW)) u_res (
        .din  (w_nxt),
        .neg  (r_neg),
        .dout (w_res)
    );

    // Last iteration: all bits consumed, or (optionally) no set bits remain.
    assign w_fin = (r_cnt == c_LAST) ||
                   ((EARLY_TERM != 0) && ((r_x >> 1) == '0));

    // Controller and datapath registers, including the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_x     <= w_abs_a;
                        r_y     <= w_abs_b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_acc <= w_nxt;
                    r_x   <= r_x >> 1;
                    r_cnt <= r_cnt + c_CW'(1);
                    if (w_fin) begin
                        product <= w_res;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : seq_mult_param
`default_nettype wire

// File: tb/tb_seq_mult_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_mult_param
//  Description : Self-checking bench for seq_mult_param. Three instances:
//                WIDTH=6 full-latency, WIDTH=6 early-terminating, WIDTH=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mult_param;

    logic        clk;
    logic        rst;
    logic [2:0]  st;
    logic        sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [11:0] p0;
    logic [11:0] p1;
    logic [15:0] p2;
    logic [15:0] prod [3];

    int checks;
    int errors;

    int c_W  [3] = '{6, 6, 8};
    int c_ET [3] = '{0, 1, 0};

    seq_mult_param #(.WIDTH(6), .EARLY_TERM(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .signed_mode(sm),
        .a(a[5:0]), .b(b[5:0]), .busy(busy_v[0]), .done(done_v[0]), .product(p0)
    );
    seq_mult_param #(.WIDTH(6), .EARLY_TERM(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .signed_mode(sm),
        .a(a[5:0]), .b(b[5:0]), .busy(busy_v[1]), .done(done_v[1]), .product(p1)
    );
    seq_mult_param #(.WIDTH(8), .EARLY_TERM(0)) u_dut2 (
        .clk(clk), .rst(rst), .start(st[2]), .signed_mode(sm),
        .a(a), .b(b), .busy(busy_v[2]), .done(done_v[2]), .product(p2)
    );

    assign prod[0] = {4'b0, p0};
    assign prod[1] = {4'b0, p1};
    assign prod[2] = p2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: signed/unsigned integer product and iteration count from
    // the operand magnitudes, computed with plain arithmetic.
    function automatic void ref_model(input int w, input int et, input bit s,
                                      input logic [7:0] aa, input logic [7:0] bb,
                                      output logic [15:0] p, output int lat);
        longint av, bv, mag, full;
        int bl;
        av = longint'(aa) & ((64'd1 << w) - 1);
        bv = longint'(bb) & ((64'd1 << w) - 1);
        if (s && av >= (64'd1 << (w - 1))) av = av - (64'd1 << w);
        if (s && bv >= (64'd1 << (w - 1))) bv = bv - (64'd1 << w);
        full = (av * bv) & ((64'd1 << (2 * w)) - 1);
        p = full[15:0];
        if (et == 0) begin
            lat = w;
        end else begin
            mag = (av < 0) ? -av : av;
            bl  = 0;
            while (mag > 0) begin
                bl++;
                mag = mag >> 1;
            end
            lat = (bl < 1) ? 1 : bl;
        end
    endfunction

    // Present a start pulse that the next rising edge samples.
    task automatic start_now(input int k, input bit s, input logic [7:0] aa, input logic [7:0] bb);
        sm = s; a = aa; b = bb;
        st[k] = 1'b1;
        @(posedge clk); #1;
        st[k] = 1'b0;
    endtask

    // Count edges until done, and cycles in which busy was high.
    task automatic wait_done(input int k, output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy_v[k] ? 1 : 0;
        while (!done_v[k] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy_v[k]) bcnt++;
        end
        if (!done_v[k]) chk("done_timeout", 0, 1);
    endtask

    task automatic do_op(input int k, input bit s, input logic [7:0] aa, input logic [7:0] bb,
                         output logic [15:0] p, output int lat, output int bcnt);
        @(negedge clk);
        start_now(k, s, aa, bb);
        wait_done(k, lat, bcnt);
        p = prod[k];
    endtask

    typedef struct {
        int          inst;
        bit          s;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        int          lat;
    } vec_t;

    initial begin
        vec_t        tbl [8];
        logic [15:0] p, ep;
        int          lat, elat, bcnt, k;
        bit          s, saw_done;
        logic [7:0]  ra, rb;

        checks = 0; errors = 0;
        st = '0; sm = 1'b0; a = '0; b = '0;

        tbl[0] = '{0, 1'b0, 8'd63,  8'd63,  16'h0F81, 6};
        tbl[1] = '{0, 1'b1, 8'h20,  8'h20,  16'h0400, 6};
        tbl[2] = '{0, 1'b1, 8'h3B,  8'h07,  16'h0FDD, 6};
        tbl[3] = '{1, 1'b0, 8'd1,   8'd45,  16'd45,   1};
        tbl[4] = '{1, 1'b0, 8'd0,   8'd9,   16'd0,    1};
        tbl[5] = '{1, 1'b1, 8'h3F,  8'h05,  16'h0FFB, 1};
        tbl[6] = '{2, 1'b0, 8'd255, 8'd255, 16'hFE01, 8};
        tbl[7] = '{2, 1'b1, 8'h80,  8'h7F,  16'hC080, 8};

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_busy%0d", i), busy_v[i], 0);
            chk($sformatf("reset_done%0d", i), done_v[i], 0);
            chk($sformatf("reset_product%0d", i), prod[i], 0);
        end

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].inst, tbl[i].s, tbl[i].a, tbl[i].b, p, lat, bcnt);
            chk($sformatf("vec%0d_product", i), p, tbl[i].p);
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("vec%0d_busy_cycles", i), bcnt, tbl[i].lat);
        end

        // start while busy is ignored; start in the done cycle is accepted
        @(negedge clk);
        start_now(0, 1'b0, 8'd5, 8'd5);
        @(negedge clk);
        sm = 1'b1; a = 8'd2; b = 8'd2; st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        wait_done(0, lat, bcnt);
        chk("busy_start_product", prod[0], 25);
        chk("busy_start_latency", lat, 5);
        start_now(0, 1'b0, 8'd2, 8'd2);
        chk("done_cycle_start_busy", busy_v[0], 1);
        wait_done(0, lat, bcnt);
        chk("done_cycle_start_product", prod[0], 4);
        chk("done_cycle_start_latency", lat, 6);

        // Reset at the third CALC edge discards the operation
        @(negedge clk);
        start_now(0, 1'b0, 8'd10, 8'd10);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midreset_busy", busy_v[0], 0);
        chk("midreset_done", done_v[0], 0);
        chk("midreset_product", prod[0], 0);
        saw_done = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done_v[0]) saw_done = 1'b1;
        end
        chk("midreset_no_done", saw_done, 0);
        do_op(0, 1'b0, 8'd3, 8'd4, p, lat, bcnt);
        chk("after_reset_product", p, 12);
        chk("after_reset_latency", lat, 6);

        // Randomised operations against the reference model
        for (int i = 0; i < 60; i++) begin
            k  = $urandom_range(0, 2);
            s  = 1'($urandom);
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i % 10 == 0) ra = (c_W[k] == 8) ? 8'h80 : 8'h20;
            if (i % 10 == 1) ra = 8'h00;
            if (c_W[k] == 6) begin
                ra[7:6] = 2'b00;
                rb[7:6] = 2'b00;
            end
            ref_model(c_W[k], c_ET[k], s, ra, rb, ep, elat);
            do_op(k, s, ra, rb, p, lat, bcnt);
            chk($sformatf("rand%0d_i%0d_s%0d_%0h*%0h_product", i, k, s, ra, rb), p, ep);
            chk($sformatf("rand%0d_i%0d_latency", i, k), lat, elat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_mult_param
`default_nettype wire
